gate_exerciser: RTL and testbench
=================================

# gate_exerciser

Self-checking stimulus driver for a 2-input combinational gate such as the team's NAND primitive. It drives the gate's `a`/`b` inputs through all four input combinations, samples the gate's `y` output after a settle time, and compares the captured truth table against an expected pattern. It sits on the driving and checking side of a gate under test, on-board or in a bench, and reports pass/fail through registered status outputs.

## Interface
Parameters:
- `SETTLE`, default 2: cycles each vector is held before `y` is sampled. Legal range is 1..15; 0 is illegal.
- `EXPECT`, default 4'b0111: expected truth table. Bit index is {a,b}. The default encodes NAND: 00→1, 01→1, 10→1, 11→0.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to run a test sequence. Honoured only in IDLE.
- `y`  in  1  output of the gate under test. Same clock domain; combinational from `a`/`b`.
- `a`  out  1  gate input A, registered.
- `b`  out  1  gate input B, registered.
- `busy`  out  1  high from the first DRIVE cycle through the last SAMPLE cycle.
- `done`  out  1  one-cycle pulse in the DONE state.
- `pass`  out  1  1 when `captured == EXPECT`. Valid from `done` until the next accepted `start`.
- `captured`  out  4  sampled `y` per vector, indexed by {a,b}.
- `fail_vec`  out  4  `captured ^ EXPECT`.

## Operation
- The FSM has four states: IDLE, DRIVE, SAMPLE, DONE.
- Internal registers:
  - 2-bit vector index `vec`.
  - 4-bit settle counter `cnt`.
- IDLE:
  - `a = b = 0`.
  - `start = 1` moves to DRIVE, sets `vec = 0`, loads `cnt = SETTLE-1`, and clears `captured`, `fail_vec` and `pass`.
  - Otherwise stay in IDLE; `pass`, `captured` and `fail_vec` hold their last results.
- DRIVE:
  - `{a,b} = vec`.
  - `cnt` decrements each cycle.
  - When `cnt == 0`, go to SAMPLE.
- SAMPLE:
  - `{a,b}` are still held at `vec`.
  - At the exiting edge, `captured[vec] <= y`.
  - If `vec == 3`, go to DONE.
  - Otherwise `vec <= vec+1`, reload `cnt = SETTLE-1`, and go to DRIVE.
- DONE:
  - `done = 1` for this cycle only.
  - `fail_vec` and `pass` update at the edge entering DONE, so they are already valid while `done` is high.
  - `a = b = 0`.
  - Next state is IDLE.
- Boundary conditions:
  - `start` asserted outside IDLE (DRIVE, SAMPLE or DONE) is ignored. It is not queued.
  - `rst` asserted at any time aborts immediately and asynchronously and returns to IDLE with all outputs at their reset values.
  - `vec` never wraps during a run. The run ends after vector 3.
  - `y` is sampled only in SAMPLE. Glitches on `y` during DRIVE have no effect.

## Timing
- Reset values: `a = 0`, `b = 0`, `busy = 0`, `done = 0`, `pass = 0`, `captured = 0`, `fail_vec = 0`. State is IDLE, `vec = 0`, `cnt = 0`.
- Take the edge at which `start` is sampled as edge 0.
- Vector i:
  - is driven on `a`/`b` from cycle 1 + i·(SETTLE+1);
  - is sampled at the end of cycle (i+1)·(SETTLE+1).
- `done` is high in cycle 4·(SETTLE+1)+1. With SETTLE = 2, that is cycle 13.
- `busy` is high in cycles 1 .. 4·(SETTLE+1).
- The earliest next accepted `start` is in the first IDLE cycle after DONE, which is cycle 4·(SETTLE+1)+2.
- `y` is consumed one or more cycles after `a`/`b` change, so the gate's combinational path must meet a single cycle.

## Test plan
- **NAND DUT, SETTLE = 2, pulse `start`:** `a`/`b` step through 00, 01, 10, 11 for 3 cycles each. Then `done` in cycle 13, `captured = 4'b0111`, `fail_vec = 0`, `pass = 1`.
- **AND DUT substituted:** `captured = 4'b1000`, `fail_vec = 4'b1111`, `pass = 0`.
- **`y` stuck at 1:** `captured = 4'b1111`, `fail_vec = 4'b1000`, `pass = 0`. Results hold until the next `start`, then clear to 0 on acceptance.
- **`start` re-pulsed in cycles 5 and 13 (DRIVE and DONE):** both pulses are ignored. Exactly one `done`, in cycle 13, and `busy` drops after cycle 12.
- **`rst` asserted mid-cycle during vector 2:** all outputs go to 0 immediately without waiting for `clk`. A fresh `start` after reset release yields a full run with `done` 13 cycles later.
- **SETTLE = 1, NAND DUT:** each vector is held 2 cycles, `done` in cycle 9, `pass = 1`.

Source files
------------

// File: rtl/gate_exerciser.sv
// gate_exerciser: drives a 2-input gate through all four input combinations,
// samples its output after a settle time and compares the captured truth
// table against EXPECT. Results are held until the next accepted start.
//
// SETTLE must be in the range 1..15. A value of 0 is not supported.
module gate_exerciser #(
  parameter int unsigned SETTLE = 2,
  parameter logic [3:0]  EXPECT = 4'b0111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] captured,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] ab_q, ab_d;
  logic [3:0] cap_q, cap_d;
  logic [3:0] fail_q, fail_d;
  logic       pass_q, pass_d;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = DRIVE;
      DRIVE:   if (cnt_q == 4'd0) state_d = SAMPLE;
      SAMPLE:  state_d = (vec_q == 2'd3) ? DONE : DRIVE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: vector index, settle counter, gate inputs, results.
  // a/b are computed from the next state so the registered outputs change
  // on the same edge the FSM enters the new vector.
  always_comb begin
    vec_d  = vec_q;
    cnt_d  = cnt_q;
    cap_d  = cap_q;
    fail_d = fail_q;
    pass_d = pass_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          vec_d  = 2'd0;
          cnt_d  = CNT_LOAD;
          cap_d  = '0;
          fail_d = '0;
          pass_d = 1'b0;
        end
      end
      DRIVE: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      end
      SAMPLE: begin
        cap_d[vec_q] = y;
        if (vec_q == 2'd3) begin
          fail_d = cap_d ^ EXPECT;
          pass_d = (fail_d == 4'd0);
        end else begin
          vec_d = vec_q + 2'd1;
          cnt_d = CNT_LOAD;
        end
      end
      default: ;
    endcase
    ab_d = ((state_d == DRIVE) || (state_d == SAMPLE)) ? vec_d : 2'b00;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q  <= '0;
      cnt_q  <= '0;
      ab_q   <= '0;
      cap_q  <= '0;
      fail_q <= '0;
      pass_q <= 1'b0;
    end else begin
      vec_q  <= vec_d;
      cnt_q  <= cnt_d;
      ab_q   <= ab_d;
      cap_q  <= cap_d;
      fail_q <= fail_d;
      pass_q <= pass_d;
    end
  end

  // Output decode from the registered state
  always_comb begin
    busy = (state_q == DRIVE) || (state_q == SAMPLE);
    done = (state_q == DONE);
  end

  assign a        = ab_q[1];
  assign b        = ab_q[0];
  assign pass     = pass_q;
  assign captured = cap_q;
  assign fail_vec = fail_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// Directed bench for gate_exerciser: behavioural gate models (NAND, AND,
// stuck-at-1, optional glitch) feed y; a second instance runs SETTLE = 1.
module tb_gate_exerciser;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start2;
  logic       y, y2;
  logic       a, b, busy, done, pass;
  logic       a2, b2, busy2, done2, pass2;
  logic [3:0] captured, fail_vec, captured2, fail_vec2;

  int         mode;    // 0 NAND, 1 AND, 2 stuck-at-1
  logic       glitch;
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  always_comb begin
    unique case (mode)
      1:       y = (a & b) ^ glitch;
      2:       y = 1'b1 ^ glitch;
      default: y = ~(a & b) ^ glitch;
    endcase
    y2 = ~(a2 & b2);
  end

  gate_exerciser #(.SETTLE(2), .EXPECT(4'b0111)) dut (
    .clk(clk), .rst(rst), .start(start), .y(y),
    .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
    .captured(captured), .fail_vec(fail_vec)
  );

  gate_exerciser #(.SETTLE(1), .EXPECT(4'b0111)) dut1 (
    .clk(clk), .rst(rst), .start(start2), .y(y2),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .pass(pass2),
    .captured(captured2), .fail_vec(fail_vec2)
  );

  // Pulse start for one edge; returns at the falling edge inside cycle 1.
  task automatic pulse_start(input bit second);
    @(negedge clk);
    if (second) start2 = 1'b1; else start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #12;
    n_checks++;
    if ({a, b, busy, done, pass, captured, fail_vec} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %b required 0", {a, b, busy, done, pass, captured, fail_vec});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done, a, b} !== 4'b0000) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b required 0000", {busy, done, a, b});
    end
  endtask

  // Full NAND run with y glitching during DRIVE cycles only.
  task automatic test_nand;
    logic [3:0] exp_sig;
    mode = 0;
    pulse_start(1'b0);
    for (int c = 1; c <= 12; c++) begin
      glitch  = ((c - 1) % 3) != 2;
      exp_sig = {1'b1, 1'b0, 2'((c - 1) / 3)};
      n_checks++;
      if ({busy, done, a, b} !== exp_sig) begin
        n_fail++;
        $display("FAIL nand_cycle%0d busy/done/a/b: got %b required %b", c, {busy, done, a, b}, exp_sig);
      end
      @(negedge clk);
    end
    glitch = 1'b0;
    n_checks++;
    if ({busy, done, a, b} !== 4'b0100) begin
      n_fail++;
      $display("FAIL nand_done_cycle13: got %b required 0100", {busy, done, a, b});
    end
    n_checks++;
    if ({pass, captured, fail_vec} !== 9'b1_0111_0000) begin
      n_fail++;
      $display("FAIL nand_results: pass/cap/fail got %b required 1_0111_0000", {pass, captured, fail_vec});
    end
    @(negedge clk);
    n_checks++;
    if ({done, pass, captured} !== 6'b0_1_0111) begin
      n_fail++;
      $display("FAIL nand_hold_cycle14: got %b required 010111", {done, pass, captured});
    end
  endtask

  task automatic test_and;
    mode = 1;
    pulse_start(1'b0);
    n_checks++;
    if ({pass, captured, fail_vec} !== 9'd0) begin
      n_fail++;
      $display("FAIL and_clear_on_start: got %b required 0", {pass, captured, fail_vec});
    end
    repeat (12) @(negedge clk);
    n_checks++;
    if ({done, pass, captured, fail_vec} !== 10'b1_0_1000_1111) begin
      n_fail++;
      $display("FAIL and_results: done/pass/cap/fail got %b required 1_0_1000_1111", {done, pass, captured, fail_vec});
    end
  endtask

  task automatic test_stuck_and_clear;
    mode = 2;
    pulse_start(1'b0);
    repeat (12) @(negedge clk);
    n_checks++;
    if ({done, pass, captured, fail_vec} !== 10'b1_0_1111_1000) begin
      n_fail++;
      $display("FAIL stuck_results: got %b required 1_0_1111_1000", {done, pass, captured, fail_vec});
    end
    repeat (6) @(negedge clk);
    n_checks++;
    if ({busy, pass, captured, fail_vec} !== 10'b0_0_1111_1000) begin
      n_fail++;
      $display("FAIL stuck_hold_idle: got %b required 0_0_1111_1000", {busy, pass, captured, fail_vec});
    end
    mode = 0;
    pulse_start(1'b0);
    n_checks++;
    if ({busy, pass, captured, fail_vec} !== 10'b1_0_0000_0000) begin
      n_fail++;
      $display("FAIL stuck_clear_on_start: got %b required 1_0_0000_0000", {busy, pass, captured, fail_vec});
    end
    repeat (14) @(negedge clk);
  endtask

  // start re-pulsed in cycle 5 (DRIVE) and cycle 13 (DONE) must be ignored.
  task automatic test_start_ignored;
    int n_done;
    int last_busy;
    mode   = 0;
    n_done = 0;
    last_busy = 0;
    pulse_start(1'b0);
    for (int c = 1; c <= 22; c++) begin
      start = (c == 5) || (c == 13);
      if (done) n_done++;
      if (busy) last_busy = c;
      if (c == 13) begin
        n_checks++;
        if (done !== 1'b1) begin
          n_fail++;
          $display("FAIL ignore_done_cycle13: got %b required 1", done);
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++;
    if (n_done !== 1) begin
      n_fail++;
      $display("FAIL ignore_done_count: got %0d required 1", n_done);
    end
    n_checks++;
    if (last_busy !== 12) begin
      n_fail++;
      $display("FAIL ignore_last_busy_cycle: got %0d required 12", last_busy);
    end
  endtask

  task automatic test_async_reset;
    mode = 0;
    pulse_start(1'b0);
    repeat (7) @(negedge clk);  // cycle 8: vector 2, a=1 b=0
    n_checks++;
    if ({busy, a, b, captured} !== 7'b1_1_0_0011) begin
      n_fail++;
      $display("FAIL rst_pre_state: busy/a/b/cap got %b required 1_1_0_0011", {busy, a, b, captured});
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({a, b, busy, done, pass, captured, fail_vec} !== 11'd0) begin
      n_fail++;
      $display("FAIL rst_async_clear: got %b required 0", {a, b, busy, done, pass, captured, fail_vec});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_stays_idle: got %b required 00", {busy, done});
    end
    pulse_start(1'b0);
    repeat (12) @(negedge clk);
    n_checks++;
    if ({done, pass, captured, fail_vec} !== 10'b1_1_0111_0000) begin
      n_fail++;
      $display("FAIL rst_rerun_results: got %b required 1_1_0111_0000", {done, pass, captured, fail_vec});
    end
    @(negedge clk);
  endtask

  task automatic test_settle1;
    logic [3:0] exp_sig;
    pulse_start(1'b1);
    for (int c = 1; c <= 8; c++) begin
      exp_sig = {1'b1, 1'b0, 2'((c - 1) / 2)};
      n_checks++;
      if ({busy2, done2, a2, b2} !== exp_sig) begin
        n_fail++;
        $display("FAIL s1_cycle%0d busy/done/a/b: got %b required %b", c, {busy2, done2, a2, b2}, exp_sig);
      end
      @(negedge clk);
    end
    n_checks++;
    if ({busy2, done2, pass2, captured2, fail_vec2} !== 11'b0_1_1_0111_0000) begin
      n_fail++;
      $display("FAIL s1_done_cycle9: got %b required 0_1_1_0111_0000", {busy2, done2, pass2, captured2, fail_vec2});
    end
    @(negedge clk);
  endtask

  initial begin
    start  = 1'b0;
    start2 = 1'b0;
    mode   = 0;
    glitch = 1'b0;
    test_reset();
    test_nand();
    test_and();
    test_stuck_and_clear();
    test_start_ignored();
    test_async_reset();
    test_settle1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
